// File: rtl/lcd_ctrl_pkg.sv
// Shared command encodings, FSM states and defaults for the LCD window controller.
package lcd_ctrl_pkg;

  localparam int unsigned DW_DEFAULT = 8;

  typedef enum logic [2:0] {
    CMD_REFRESH  = 3'd0,
    CMD_LOAD     = 3'd1,
    CMD_ZOOM_IN  = 3'd2,
    CMD_ZOOM_OUT = 3'd3,
    CMD_RIGHT    = 3'd4,
    CMD_LEFT     = 3'd5,
    CMD_UP       = 3'd6,
    CMD_DOWN     = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_UPDATE  = 2'd2,
    ST_REFRESH = 2'd3
  } state_e;

endpackage

// File: rtl/lcd_win_addr.sv
// Maps (zoom mode, origin, window col/row) to frame buffer address(es).
// With LCD_WINDOW_AVG_EN the full 2x2 address set of the zoomed-out block is produced.
module lcd_win_addr #(
  parameter int unsigned WIN_W = 4,
  parameter int unsigned WIN_H = 4,
  localparam int unsigned ImgW = 2 * WIN_W,
  localparam int unsigned ImgH = 2 * WIN_H,
  localparam int unsigned XW   = $clog2(ImgW),
  localparam int unsigned YW   = $clog2(ImgH),
  localparam int unsigned CW   = (WIN_W > 1) ? $clog2(WIN_W) : 1,
  localparam int unsigned RW   = (WIN_H > 1) ? $clog2(WIN_H) : 1,
  localparam int unsigned AW   = $clog2(ImgW * ImgH)
) (
  input  logic          zoomed_i,
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  input  logic [CW-1:0] col_i,
  input  logic [RW-1:0] row_i,
  output logic [AW-1:0] addr_o
`ifdef LCD_WINDOW_AVG_EN
  ,
  output logic [AW-1:0] addr01_o,
  output logic [AW-1:0] addr10_o,
  output logic [AW-1:0] addr11_o
`endif
);

  logic [AW-1:0] zin_row, zin_col, zout_row, zout_col, zin_addr, zout_addr;

  assign zin_row   = AW'(y_i) + AW'(row_i);
  assign zin_col   = AW'(x_i) + AW'(col_i);
  assign zout_row  = AW'(row_i) << 1;
  assign zout_col  = AW'(col_i) << 1;
  assign zin_addr  = zin_row * AW'(ImgW) + zin_col;
  assign zout_addr = zout_row * AW'(ImgW) + zout_col;
  assign addr_o    = zoomed_i ? zin_addr : zout_addr;

`ifdef LCD_WINDOW_AVG_EN
  assign addr01_o = zout_addr + AW'(1);
  assign addr10_o = zout_addr + AW'(ImgW);
  assign addr11_o = zout_addr + AW'(ImgW + 1);
`endif

endmodule

// File: rtl/lcd_window_ctrl.sv
// Frame-buffered LCD window controller: LOAD a frame, stream a zoomed/decimated window.
// Define LCD_WINDOW_AVG_EN for 2x2 averaging in zoomed-out mode instead of decimation.
module lcd_window_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned WIN_W = 4,
  parameter int unsigned WIN_H = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [2:0]    cmd,
  input  logic          cmd_valid,
  input  logic [DW-1:0] datain,
  output logic [DW-1:0] dataout,
  output logic          output_valid,
  output logic          busy
);

  localparam int unsigned ImgW = 2 * WIN_W;
  localparam int unsigned ImgH = 2 * WIN_H;
  localparam int unsigned NPix = ImgW * ImgH;
  localparam int unsigned XW   = $clog2(ImgW);
  localparam int unsigned YW   = $clog2(ImgH);
  localparam int unsigned CW   = (WIN_W > 1) ? $clog2(WIN_W) : 1;
  localparam int unsigned RW   = (WIN_H > 1) ? $clog2(WIN_H) : 1;
  localparam int unsigned AW   = $clog2(NPix);
  localparam int unsigned XMax = ImgW - WIN_W;
  localparam int unsigned YMax = ImgH - WIN_H;

  state_e        state_q, state_d;
  cmd_e          cmd_q, cmd_d;
  logic          zoomed_q, zoomed_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] load_cnt_q, load_cnt_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          fb_we;
  logic [DW-1:0] fb_q [NPix];

  logic          accept, load_last, win_last;
  logic [AW-1:0] addr;
  logic [DW-1:0] pix;

  assign accept    = (state_q == ST_IDLE) && cmd_valid && !busy_q;
  assign load_last = (load_cnt_q == AW'(NPix - 1));
  assign win_last  = (col_q == CW'(WIN_W - 1)) && (row_q == RW'(WIN_H - 1));

`ifdef LCD_WINDOW_AVG_EN
  localparam int unsigned SW = DW + 2;
  logic [AW-1:0] addr01, addr10, addr11;
  logic [SW-1:0] avg_sum;

  lcd_win_addr #(.WIN_W(WIN_W), .WIN_H(WIN_H)) u_addr (
    .zoomed_i (zoomed_q),
    .x_i      (x_q),
    .y_i      (y_q),
    .col_i    (col_q),
    .row_i    (row_q),
    .addr_o   (addr),
    .addr01_o (addr01),
    .addr10_o (addr10),
    .addr11_o (addr11)
  );

  // Round-half-up mean of the 2x2 block; the DW+2 bit sum cannot overflow.
  assign avg_sum = SW'(fb_q[addr]) + SW'(fb_q[addr01]) + SW'(fb_q[addr10])
                 + SW'(fb_q[addr11]) + SW'(2);
  assign pix     = zoomed_q ? fb_q[addr] : avg_sum[SW-1:2];
`else
  lcd_win_addr #(.WIN_W(WIN_W), .WIN_H(WIN_H)) u_addr (
    .zoomed_i (zoomed_q),
    .x_i      (x_q),
    .y_i      (y_q),
    .col_i    (col_q),
    .row_i    (row_q),
    .addr_o   (addr)
  );

  assign pix = fb_q[addr];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd == CMD_LOAD)         state_d = ST_LOAD;
          else if (cmd == CMD_REFRESH) state_d = ST_REFRESH;
          else                         state_d = ST_UPDATE;
        end
      end
      ST_LOAD:    if (load_last) state_d = ST_REFRESH;
      ST_UPDATE:  state_d = ST_REFRESH;
      ST_REFRESH: if (win_last) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_d      = cmd_q;
    zoomed_d   = zoomed_q;
    x_d        = x_q;
    y_d        = y_q;
    load_cnt_d = load_cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    dout_d     = dout_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    fb_we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // busy still high on the first idle cycle, so a command can't sneak in there
        valid_d = 1'b0;
        busy_d  = accept;
        if (accept) begin
          cmd_d      = cmd_e'(cmd);
          load_cnt_d = '0;
          col_d      = '0;
          row_d      = '0;
        end
      end
      ST_LOAD: begin
        fb_we      = 1'b1;
        load_cnt_d = load_cnt_q + AW'(1);
        if (load_last) begin
          zoomed_d = 1'b0;
          x_d      = '0;
          y_d      = '0;
        end
      end
      ST_UPDATE: begin
        case (cmd_q)
          CMD_ZOOM_IN: begin
            zoomed_d = 1'b1;
            x_d      = XW'(XMax / 2);
            y_d      = YW'(YMax / 2);
          end
          CMD_ZOOM_OUT: begin
            zoomed_d = 1'b0;
            x_d      = '0;
            y_d      = '0;
          end
          CMD_RIGHT: if (zoomed_q && x_q < XW'(XMax)) x_d = x_q + XW'(1);
          CMD_LEFT:  if (zoomed_q && x_q != '0)       x_d = x_q - XW'(1);
          CMD_UP:    if (zoomed_q && y_q != '0)       y_d = y_q - YW'(1);
          CMD_DOWN:  if (zoomed_q && y_q < YW'(YMax)) y_d = y_q + YW'(1);
          default: ;
        endcase
      end
      ST_REFRESH: begin
        valid_d = 1'b1;
        dout_d  = pix;
        if (col_q == CW'(WIN_W - 1)) begin
          col_d = '0;
          row_d = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q      <= CMD_REFRESH;
      zoomed_q   <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      load_cnt_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cmd_q      <= cmd_d;
      zoomed_q   <= zoomed_d;
      x_q        <= x_d;
      y_q        <= y_d;
      load_cnt_q <= load_cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  // Frame buffer is deliberately left out of reset so a frame survives an abort.
  always_ff @(posedge clk) begin
    if (fb_we) fb_q[load_cnt_q] <= datain;
  end

  assign dataout      = dout_q;
  assign output_valid = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_lcd_window_ctrl.sv
// Directed + randomized bench for lcd_window_ctrl against a frame/origin reference model.
// Honours LCD_WINDOW_AVG_EN in the reference model when defined.
module tb_lcd_window_ctrl;

  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int WIN_W = 4;
  localparam int WIN_H = 4;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NWIN  = WIN_W * WIN_H;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] datain;
  logic [7:0] dataout;
  logic       output_valid;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;
  int frame [NPIX];
  int m_zoom, m_x, m_y;
  int first_pix;

  always #5 clk = ~clk;

  lcd_window_ctrl #(.DW(8), .WIN_W(WIN_W), .WIN_H(WIN_H)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .datain       (datain),
    .dataout      (dataout),
    .output_valid (output_valid),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_pix(input int c, input int r);
    int b;
    if (m_zoom != 0) return frame[(m_y + r) * IMG_W + m_x + c];
    b = 2 * r * IMG_W + 2 * c;
`ifdef LCD_WINDOW_AVG_EN
    return (frame[b] + frame[b + 1] + frame[b + IMG_W] + frame[b + IMG_W + 1] + 2) / 4;
`else
    return frame[b];
`endif
  endfunction

  task automatic model_cmd(input int c);
    case (c)
      1: begin m_zoom = 0; m_x = 0; m_y = 0; end
      2: begin m_zoom = 1; m_x = (IMG_W - WIN_W) / 2; m_y = (IMG_H - WIN_H) / 2; end
      3: begin m_zoom = 0; m_x = 0; m_y = 0; end
      4: if (m_zoom != 0 && m_x < IMG_W - WIN_W) m_x++;
      5: if (m_zoom != 0 && m_x > 0) m_x--;
      6: if (m_zoom != 0 && m_y > 0) m_y--;
      7: if (m_zoom != 0 && m_y < IMG_H - WIN_H) m_y++;
      default: ;
    endcase
  endtask

  // mode 0: plain, 1: cmd_valid pulse mid-stream, 2: reset at beat 7
  task automatic run_cmd(input int c, input int mode);
    int n, lat;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_before_cmd", {31'b0, busy}, 0);
    cmd       = 3'(c);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("busy_after_accept", {31'b0, busy}, 1);
    if (c == 1) begin
      for (int i = 0; i < NPIX; i++) begin
        datain = 8'(frame[i]);
        @(posedge clk);
        #1;
      end
      check("busy_through_load", {31'b0, busy}, 1);
    end
    model_cmd(c);
    lat = (c == 0 || c == 1) ? 1 : 2;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (output_valid !== 1'b1 && n < lat + 6);
    check("first_valid_latency", n - 1, lat);
    for (int k = 0; k < NWIN; k++) begin
      if (k > 0) @(negedge clk);
      check("beat_valid", {31'b0, output_valid}, 1);
      check("beat_busy", {31'b0, busy}, 1);
      check("beat_data", {24'b0, dataout}, exp_pix(k % WIN_W, k / WIN_W));
      if (k == 0) first_pix = int'(dataout);
      if (mode == 1 && k == 5) begin
        cmd       = 3'd2;
        cmd_valid = 1'b1;
      end
      if (mode == 1 && k == 6) cmd_valid = 1'b0;
      if (mode == 2 && k == 7) begin
        reset_n = 1'b0;
        #1;
        check("reset_busy", {31'b0, busy}, 0);
        check("reset_valid", {31'b0, output_valid}, 0);
        check("reset_dataout", {24'b0, dataout}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        m_zoom = 0; m_x = 0; m_y = 0;
        return;
      end
    end
    @(negedge clk);
    check("end_valid_low", {31'b0, output_valid}, 0);
    check("end_busy_low", {31'b0, busy}, 0);
    check("end_data_hold", {24'b0, dataout}, exp_pix(WIN_W - 1, WIN_H - 1));
    if (mode == 1) begin
      repeat (4) begin
        @(negedge clk);
        check("ignored_cmd_no_busy", {31'b0, busy}, 0);
        check("ignored_cmd_no_valid", {31'b0, output_valid}, 0);
      end
    end
  endtask

  initial begin
    int c;
    reset_n   = 1'b0;
    cmd       = 3'd0;
    cmd_valid = 1'b0;
    datain    = 8'd0;
    m_zoom = 0; m_x = 0; m_y = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_valid", {31'b0, output_valid}, 0);
    check("rst_dataout", {24'b0, dataout}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", {31'b0, busy}, 0);

    for (int i = 0; i < NPIX; i++) frame[i] = i;
    run_cmd(1, 0);
`ifdef LCD_WINDOW_AVG_EN
    check("load_first_pix", first_pix, 5);
`else
    check("load_first_pix", first_pix, 0);
`endif
    run_cmd(2, 0);
    check("zoom_in_first_pix", first_pix, 18);
    repeat (3) run_cmd(4, 0);
    check("right_sat_first_pix", first_pix, 20);
    repeat (3) run_cmd(6, 0);
    check("up_sat_first_pix", first_pix, 4);
    run_cmd(3, 0);
    run_cmd(5, 0);
`ifdef LCD_WINDOW_AVG_EN
    check("left_zoomed_out_first_pix", first_pix, 5);
`else
    check("left_zoomed_out_first_pix", first_pix, 0);
`endif
    run_cmd(0, 1);
    run_cmd(2, 0);
    run_cmd(0, 2);
    run_cmd(0, 0);

    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NPIX; i++) frame[i] = int'($urandom_range(0, 255));
      run_cmd(1, 0);
      for (int s = 0; s < 14; s++) begin
        c = int'($urandom_range(0, 6));
        if (c == 1) c = 0;
        if (c == 6) c = int'($urandom_range(6, 7));
        run_cmd(c, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
